// File: rtl/pdm_pkg.sv
// Shared types and elaboration helpers for the multichannel PDM capture block.
package pdm_pkg;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} serial_state_t;

    // Bit growth of an N-stage CIC with decimation r, plus sign and headroom
    function automatic int cic_width(input int stages, input int r);
        return stages * $clog2(r) + 2;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit half_ok(input int clk_freq, input int pdm_freq);
        return (clk_freq % (2 * pdm_freq) == 0) && (clk_freq / (2 * pdm_freq) >= 4);
    endfunction

endpackage

// File: rtl/pdm_cic_channel.sv
// One CIC decimator channel: integrators run on the channel's sample strobe,
// combs run on the shared frame tick and produce the scaled PCM word.
module pdm_cic_channel
    import pdm_pkg::*;
#(
    parameter int CIC_STAGES        = 4,
    parameter int DECIMATION_FACTOR = 64,
    parameter int DATA_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  strobe,
    input  logic                  bit_in,
    input  logic                  tick,
    output logic [DATA_WIDTH-1:0] comb_out
);

    localparam int CW = cic_width(CIC_STAGES, DECIMATION_FACTOR);

    logic [CW-1:0] integ   [CIC_STAGES];
    logic [CW-1:0] dly     [CIC_STAGES];
    logic [CW-1:0] comb_in [CIC_STAGES];
    logic [CW-1:0] acc;
    logic [CW-1:0] x;

    assign x = bit_in ? CW'(1) : '1;

    // Comb chain evaluated combinationally, committed only on the tick
    always_comb begin
        acc = integ[CIC_STAGES-1];
        for (int i = 0; i < CIC_STAGES; i++) begin
            comb_in[i] = acc;
            acc        = acc - dly[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < CIC_STAGES; i++) begin
                integ[i] <= '0;
                dly[i]   <= '0;
            end
            comb_out <= '0;
        end else begin
            if (strobe) begin
                integ[0] <= integ[0] + x;
                for (int i = 1; i < CIC_STAGES; i++)
                    integ[i] <= integ[i] + integ[i-1];
            end
            if (tick) begin
                for (int i = 0; i < CIC_STAGES; i++)
                    dly[i] <= comb_in[i];
                comb_out <= acc[CW-1 -: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/pdm_multichannel_capture.sv
// Multi-mic PDM front end: clock divider, dual-edge sampling, per-channel CIC
// decimation and a valid/ready serialiser with sticky overrun reporting.
module pdm_multichannel_capture
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int PDM_CLK_FREQ      = 2_000_000,
    parameter int NUM_MICS          = 1,
    parameter int CIC_STAGES        = 4,
    parameter int DECIMATION_FACTOR = 64,
    parameter int DATA_WIDTH        = 16,
    localparam int NCH              = 2 * NUM_MICS,
    localparam int CHW              = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  M_CLK,
    input  logic [NUM_MICS-1:0]   M_DATA,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CHW-1:0]        out_channel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int HALF  = CLK_FREQ / (2 * PDM_CLK_FREQ);
    localparam int CNT_W = $clog2(HALF);
    localparam int RW    = $clog2(DECIMATION_FACTOR);
    localparam int WW    = $clog2(CIC_STAGES + 1);

    if (!half_ok(CLK_FREQ, PDM_CLK_FREQ)) begin : g_bad_half
        $error("CLK_FREQ/(2*PDM_CLK_FREQ) must be an integer >= 4");
    end
    if (!is_pow2(DECIMATION_FACTOR) || DECIMATION_FACTOR < 4) begin : g_bad_r
        $error("DECIMATION_FACTOR must be a power of two >= 4");
    end
    if (cic_width(CIC_STAGES, DECIMATION_FACTOR) < DATA_WIDTH) begin : g_bad_w
        $error("DATA_WIDTH exceeds CIC internal width");
    end

    logic [CNT_W-1:0]    div_cnt;
    logic                m_clk_q;
    logic                half_end, strobe_fall, strobe_rise, tick;
    logic [NUM_MICS-1:0] sync1, sync2;
    logic [RW-1:0]       rise_cnt;
    logic [WW-1:0]       warm_cnt;
    logic                warm_done, frame_go, busy, emit_q;
    logic [NCH-1:0][DATA_WIDTH-1:0] pcm, hold;
    serial_state_t       state_q, state_d;
    logic                load, last_acc;

    assign half_end    = div_cnt == CNT_W'(HALF - 1);
    assign strobe_fall = enable && half_end && m_clk_q;
    assign strobe_rise = enable && half_end && !m_clk_q;
    assign tick        = strobe_rise && (&rise_cnt);
    assign warm_done   = warm_cnt == WW'(CIC_STAGES);
    assign frame_go    = tick && warm_done;
    assign M_CLK       = m_clk_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            div_cnt  <= '0;
            m_clk_q  <= 1'b0;
            rise_cnt <= '0;
            warm_cnt <= '0;
        end else begin
            if (half_end) begin
                div_cnt <= '0;
                m_clk_q <= ~m_clk_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (strobe_rise) rise_cnt <= rise_cnt + 1'b1;
            if (tick && !warm_done) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= M_DATA;
            sync2 <= sync1;
        end
    end

    // Even channels sample at the end of the high phase, odd at the end of the low phase
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        pdm_cic_channel #(
            .CIC_STAGES       (CIC_STAGES),
            .DECIMATION_FACTOR(DECIMATION_FACTOR),
            .DATA_WIDTH       (DATA_WIDTH)
        ) u_cic (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (!enable),
            .strobe  ((ch % 2 == 0) ? strobe_fall : strobe_rise),
            .bit_in  (sync2[ch/2]),
            .tick    (tick),
            .comb_out(pcm[ch])
        );
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        last_acc = 1'b0;
        case (state_q)
            IDLE: if (emit_q) begin
                state_d = SEND;
                load    = 1'b1;
            end
            SEND: if (out_ready && out_channel == CHW'(NCH - 1)) begin
                state_d  = IDLE;
                last_acc = 1'b1;
            end
        endcase
    end

    // A frame still occupying the serialiser after this cycle forces a drop
    assign busy      = (state_q == SEND) && !last_acc;
    assign out_valid = state_q == SEND;
    assign out_data  = hold[out_channel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            emit_q      <= 1'b0;
            overrun     <= 1'b0;
            hold        <= '0;
            out_channel <= '0;
        end else begin
            state_q <= state_d;
            emit_q  <= frame_go && !busy;
            if (frame_go && busy)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
            if (load) begin
                hold        <= pcm;
                out_channel <= '0;
            end else if (out_valid && out_ready) begin
                out_channel <= last_acc ? '0 : out_channel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_multichannel_capture.sv
// Directed bench: single-mic DUT for timing/values/overrun/reset, dual-mic DUT for channel order.
module tb_pdm_multichannel_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, out_ready, overrun_clr;
    logic        m_clk, m_clk2, m_data;
    logic [1:0]  mode;
    logic        tog = 1'b0;
    logic [15:0] out_data, out_data2;
    logic        out_channel;
    logic [1:0]  out_channel2;
    logic        out_valid, out_valid2, overrun, overrun2;
    logic [1:0]  m_data2 = 2'b10;
    logic        out_ready2 = 1'b1;
    logic        overrun_clr2 = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge m_clk) tog <= ~tog;
    assign m_data = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? m_clk : tog;

    pdm_multichannel_capture #(.NUM_MICS(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .M_CLK(m_clk), .M_DATA(m_data),
        .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    pdm_multichannel_capture #(.NUM_MICS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .M_CLK(m_clk2), .M_DATA(m_data2),
        .out_data(out_data2), .out_channel(out_channel2), .out_valid(out_valid2),
        .out_ready(out_ready2), .overrun(overrun2), .overrun_clr(overrun_clr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!out_valid && n < maxc) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, c0, t1, t2, bad;
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1; overrun_clr = 1'b0; mode = 2'd0;
        repeat (3) step();
        chk("rst_mclk", m_clk, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_channel", out_channel, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        n = 0;
        repeat (20) begin step(); if (m_clk) n++; end
        chk("mclk_disabled_high_cycles", n, 0);

        // M_CLK timing from enable
        enable = 1'b1; c0 = cyc;
        n = 0; while (!m_clk && n < 100) begin step(); n++; end
        chk("mclk_first_rise", n, 25);
        n = 0; while (m_clk && n < 100) begin step(); n++; end
        chk("mclk_high_len", n, 25);
        n = 0; while (!m_clk && n < 100) begin step(); n++; end
        chk("mclk_low_len", n, 25);

        // Constant-one input: nothing until the fifth tick, then 0x4000 on both channels
        wait_valid(20000);
        chk("warmup_latency", cyc - c0, 15976);
        t1 = cyc;
        chk("c1_ch0_chan", out_channel, 0);
        chk("c1_ch0_data", out_data, 16'h4000);
        chk("mic2_ch0_chan", out_channel2, 0);
        chk("mic2_ch0_data", out_data2, 16'hC000);
        step();
        chk("c1_ch1_chan", out_channel, 1);
        chk("c1_ch1_data", out_data, 16'h4000);
        chk("mic2_ch1_chan", out_channel2, 1);
        chk("mic2_ch1_data", out_data2, 16'hC000);
        step();
        chk("c1_done", out_valid, 0);
        chk("mic2_ch2_chan", out_channel2, 2);
        chk("mic2_ch2_data", out_data2, 16'h4000);
        step();
        chk("mic2_ch3_chan", out_channel2, 3);
        chk("mic2_ch3_data", out_data2, 16'h4000);
        step();
        chk("mic2_done", out_valid2, 0);

        // Stall downstream across two further ticks
        out_ready = 1'b0;
        wait_valid(4000);
        chk("frame_period", cyc - t1, 3200);
        t2 = cyc;
        chk("held_data", out_data, 16'h4000);
        bad = 0;
        while (cyc < t2 + 3300) begin
            step();
            if (!out_valid || out_channel !== 1'b0 || out_data !== 16'h4000) bad++;
        end
        chk("overrun_set", overrun, 1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);
        while (cyc < t2 + 6398) begin
            step();
            if (!out_valid || out_channel !== 1'b0 || out_data !== 16'h4000) bad++;
        end
        // clear lands on the same edge as the next dropped tick
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("clear_vs_set", overrun, 1);
        step();
        chk("overrun_sticky", overrun, 1);
        chk("held_stable_cycles_bad", bad, 0);

        out_ready = 1'b1;
        step();
        chk("drain_ch1_chan", out_channel, 1);
        chk("drain_ch1_data", out_data, 16'h4000);
        step();
        chk("drain_done", out_valid, 0);
        repeat (5) step();
        chk("no_extra_frame", out_valid, 0);

        // Phase-split input: high phase 1, low phase 0
        enable = 1'b0; mode = 2'd1;
        repeat (5) step();
        chk("mclk_off_when_disabled", m_clk, 0);
        enable = 1'b1; c0 = cyc;
        wait_valid(20000);
        chk("ps_latency", cyc - c0, 15976);
        chk("ps_ch0", out_data, 16'h4000);
        step();
        chk("ps_ch1", out_data, 16'hC000);
        step();

        // 50 % density per channel
        enable = 1'b0; mode = 2'd2;
        repeat (5) step();
        enable = 1'b1; c0 = cyc;
        wait_valid(20000);
        chk("half_latency", cyc - c0, 15976);
        chk("half_ch0", out_data, 16'h0000);
        step();
        chk("half_ch1", out_data, 16'h0000);
        step();

        // Reset while a frame is pending
        out_ready = 1'b0;
        wait_valid(4000);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_mclk", m_clk, 1);
        chk("mic2_mclk_match", m_clk2, 1);
        rst_n = 1'b0;
        step();
        chk("midrst_mclk", m_clk, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_channel", out_channel, 0);
        chk("midrst_overrun", overrun, 0);
        rst_n = 1'b1; c0 = cyc;
        wait_valid(20000);
        chk("post_rst_warmup_latency", cyc - c0, 15976);
        chk("mic2_no_overrun", overrun2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
